// File: rtl/simd_run_ctrl.sv
// Host-side sequencer for datapath_top. It takes one command at a time and
// runs it to completion. A command either streams rows into BRAM A, B or INS,
// runs the loaded program and waits for it to finish, or streams BRAM R back
// to the host.
module simd_run_ctrl #(
  parameter int PE_COUNT       = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int BRAM_DEPTH     = 1024,
  parameter int ADDR_WIDTH     = $clog2(BRAM_DEPTH),
  parameter int INS_ADDR_WIDTH = 11,
  parameter int INS_WIDTH      = 64,
  parameter int RD_LAT         = 2,
  parameter int RUN_TIMEOUT    = 65535
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [2:0]                       cmd_op,
  input  logic [INS_ADDR_WIDTH-1:0]        cmd_addr,
  input  logic [INS_ADDR_WIDTH-1:0]        cmd_len,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [PE_COUNT*DATA_WIDTH-1:0]   wr_data,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic [PE_COUNT*DATA_WIDTH-1:0]   rd_data,
  input  logic                             pause_req,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             stall,
  output logic                             in_data_valid,
  input  logic                             out_data_valid,
  output logic                             bram_a_wr_en,
  output logic [ADDR_WIDTH-1:0]            bram_a_wr_addr,
  output logic [PE_COUNT*DATA_WIDTH-1:0]   bram_a_wr_data,
  output logic                             bram_b_wr_en,
  output logic [ADDR_WIDTH-1:0]            bram_b_wr_addr,
  output logic [PE_COUNT*DATA_WIDTH-1:0]   bram_b_wr_data,
  output logic                             bram_ins_wr_en,
  output logic [INS_ADDR_WIDTH-1:0]        bram_ins_wr_addr,
  output logic [INS_WIDTH-1:0]             bram_ins_wr_data,
  output logic [INS_ADDR_WIDTH-1:0]        bram_r_r_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0]   bram_r_r_data
);

  localparam int TMO_W = $clog2(RUN_TIMEOUT + 1);
  localparam int SUB_W = 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_RD_ADDR = 3'd4;
  localparam logic [2:0] S_RD_WAIT = 3'd5;
  localparam logic [2:0] S_RD_OUT  = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  localparam logic [2:0] OP_LOAD_A   = 3'd0;
  localparam logic [2:0] OP_LOAD_B   = 3'd1;
  localparam logic [2:0] OP_LOAD_INS = 3'd2;
  localparam logic [2:0] OP_RUN      = 3'd3;
  localparam logic [2:0] OP_READ_R   = 3'd4;

  localparam logic [INS_ADDR_WIDTH-1:0] ADDR_ONE   = INS_ADDR_WIDTH'(1);
  localparam logic [TMO_W-1:0]          TMO_LAST   = TMO_W'(RUN_TIMEOUT - 1);
  localparam logic [SUB_W-1:0]          RD_LAST    = SUB_W'(RD_LAT - 1);
  localparam logic [SUB_W-1:0]          START_LAST = SUB_W'(1);

  logic [2:0]                state;
  logic [2:0]                op_q;
  logic [INS_ADDR_WIDTH-1:0] len_q;
  logic [INS_ADDR_WIDTH-1:0] cur_addr;
  logic [INS_ADDR_WIDTH-1:0] beat_cnt;
  logic [SUB_W-1:0]          sub_cnt;
  logic [TMO_W-1:0]          tmo_cnt;
  logic                      ovd_p0;
  logic                      pause_p0;
  logic                      wr_hs;
  logic                      rd_capture;

  // Handshake qualifiers and state-decoded outputs
  always_comb begin
    cmd_ready     = (state == S_IDLE) && !rst;
    wr_ready      = (state == S_LOAD);
    rd_valid      = (state == S_RD_OUT);
    in_data_valid = (state == S_START);
    stall         = (state == S_WAIT) && pause_p0;
    busy          = (state != S_IDLE);
    wr_hs         = (state == S_LOAD) && wr_valid;
    rd_capture    = (state == S_RD_WAIT) && (sub_cnt == RD_LAST);
  end

  // Command sequencer: state, beat/address counters, run timeout, done/err
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      op_q          <= 3'd0;
      len_q         <= '0;
      cur_addr      <= '0;
      beat_cnt      <= '0;
      sub_cnt       <= '0;
      tmo_cnt       <= '0;
      ovd_p0        <= 1'b0;
      pause_p0      <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      bram_r_r_addr <= '0;
    end else begin
      done     <= 1'b0;
      ovd_p0   <= out_data_valid;
      pause_p0 <= pause_req;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            len_q    <= cmd_len;
            cur_addr <= cmd_addr;
            beat_cnt <= '0;
            sub_cnt  <= '0;
            tmo_cnt  <= '0;
            err      <= 1'b0;
            case (cmd_op)
              OP_LOAD_A, OP_LOAD_B, OP_LOAD_INS: state <= S_LOAD;
              OP_RUN:                            state <= S_START;
              OP_READ_R: begin
                bram_r_r_addr <= cmd_addr;
                state         <= S_RD_ADDR;
              end
              default: begin
                // ERR cycle itself shows err and the done pulse
                err   <= 1'b1;
                done  <= 1'b1;
                state <= S_ERR;
              end
            endcase
          end
        end
        S_LOAD: begin
          if (wr_valid) begin
            cur_addr <= cur_addr + ADDR_ONE;
            beat_cnt <= beat_cnt + ADDR_ONE;
            if (beat_cnt == len_q) begin
              // done lines up with the last write enable
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_START: begin
          if (sub_cnt == START_LAST) begin
            sub_cnt <= '0;
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end else begin
            sub_cnt <= sub_cnt + SUB_W'(1);
          end
        end
        S_WAIT: begin
          // only a fresh rising edge completes; a level left over from a prior run does not
          if (out_data_valid && !ovd_p0) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (!pause_p0) begin
            if (tmo_cnt == TMO_LAST) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_ERR;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
        end
        S_RD_ADDR: begin
          sub_cnt <= '0;
          state   <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (sub_cnt == RD_LAST) begin
            state <= S_RD_OUT;
          end else begin
            sub_cnt <= sub_cnt + SUB_W'(1);
          end
        end
        S_RD_OUT: begin
          if (rd_ready) begin
            if (beat_cnt == len_q) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              cur_addr      <= cur_addr + ADDR_ONE;
              bram_r_r_addr <= cur_addr + ADDR_ONE;
              beat_cnt      <= beat_cnt + ADDR_ONE;
              state         <= S_RD_ADDR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write-port and read-data registers; address/data hold between beats
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_a_wr_en     <= 1'b0;
      bram_a_wr_addr   <= '0;
      bram_a_wr_data   <= '0;
      bram_b_wr_en     <= 1'b0;
      bram_b_wr_addr   <= '0;
      bram_b_wr_data   <= '0;
      bram_ins_wr_en   <= 1'b0;
      bram_ins_wr_addr <= '0;
      bram_ins_wr_data <= '0;
      rd_data          <= '0;
    end else begin
      bram_a_wr_en   <= 1'b0;
      bram_b_wr_en   <= 1'b0;
      bram_ins_wr_en <= 1'b0;
      if (wr_hs) begin
        case (op_q)
          OP_LOAD_A: begin
            bram_a_wr_en   <= 1'b1;
            bram_a_wr_addr <= cur_addr[ADDR_WIDTH-1:0];
            bram_a_wr_data <= wr_data;
          end
          OP_LOAD_B: begin
            bram_b_wr_en   <= 1'b1;
            bram_b_wr_addr <= cur_addr[ADDR_WIDTH-1:0];
            bram_b_wr_data <= wr_data;
          end
          OP_LOAD_INS: begin
            bram_ins_wr_en   <= 1'b1;
            bram_ins_wr_addr <= cur_addr;
            bram_ins_wr_data <= wr_data[INS_WIDTH-1:0];
          end
          default: ;
        endcase
      end
      if (rd_capture) begin
        rd_data <= bram_r_r_data;
      end
    end
  end

endmodule

// File: tb/tb_simd_run_ctrl.sv
// Directed bench for simd_run_ctrl: loads, runs, timeout, readback, illegal op
// and reset during a load, against a small BRAM R model with 2-cycle latency.
module tb_simd_run_ctrl;

  localparam int ROW_W = 128;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid, cmd_ready;
  logic [2:0]         cmd_op;
  logic [10:0]        cmd_addr, cmd_len;
  logic               wr_valid, wr_ready;
  logic [ROW_W-1:0]   wr_data;
  logic               rd_valid, rd_ready;
  logic [ROW_W-1:0]   rd_data;
  logic               pause_req, busy, done, err, stall, in_data_valid, out_data_valid;
  logic               bram_a_wr_en, bram_b_wr_en, bram_ins_wr_en;
  logic [9:0]         bram_a_wr_addr, bram_b_wr_addr;
  logic [ROW_W-1:0]   bram_a_wr_data, bram_b_wr_data;
  logic [10:0]        bram_ins_wr_addr, bram_r_r_addr;
  logic [63:0]        bram_ins_wr_data;
  logic [ROW_W-1:0]   bram_r_r_data;

  int tests = 0;
  int fails = 0;

  simd_run_ctrl #(.RUN_TIMEOUT(100)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .pause_req(pause_req), .busy(busy), .done(done), .err(err),
    .stall(stall), .in_data_valid(in_data_valid), .out_data_valid(out_data_valid),
    .bram_a_wr_en(bram_a_wr_en), .bram_a_wr_addr(bram_a_wr_addr), .bram_a_wr_data(bram_a_wr_data),
    .bram_b_wr_en(bram_b_wr_en), .bram_b_wr_addr(bram_b_wr_addr), .bram_b_wr_data(bram_b_wr_data),
    .bram_ins_wr_en(bram_ins_wr_en), .bram_ins_wr_addr(bram_ins_wr_addr),
    .bram_ins_wr_data(bram_ins_wr_data),
    .bram_r_r_addr(bram_r_r_addr), .bram_r_r_data(bram_r_r_data)
  );

  always #5 clk = ~clk;

  // BRAM R model, two-cycle read latency
  logic [ROW_W-1:0] rmem [0:2047];
  logic [ROW_W-1:0] r_p1;
  always @(posedge clk) begin
    r_p1          <= rmem[bram_r_r_addr];
    bram_r_r_data <= r_p1;
  end

  // Event monitor: counts pulses and logs write addresses/data
  int a_n = 0, b_n = 0, ins_n = 0, done_n = 0, idv_n = 0;
  logic [9:0]       a_log_addr [0:63];
  logic [ROW_W-1:0] a_log_data [0:63];
  logic [10:0]      ins_log_addr [0:63];
  logic [63:0]      ins_log_data [0:63];
  always @(negedge clk) begin
    if (bram_a_wr_en) begin
      if (a_n < 64) begin
        a_log_addr[a_n] <= bram_a_wr_addr;
        a_log_data[a_n] <= bram_a_wr_data;
      end
      a_n <= a_n + 1;
    end
    if (bram_b_wr_en) b_n <= b_n + 1;
    if (bram_ins_wr_en) begin
      if (ins_n < 64) begin
        ins_log_addr[ins_n] <= bram_ins_wr_addr;
        ins_log_data[ins_n] <= bram_ins_wr_data;
      end
      ins_n <= ins_n + 1;
    end
    if (done) done_n <= done_n + 1;
    if (in_data_valid) idv_n <= idv_n + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [10:0] addr, input logic [10:0] len);
    for (int k = 0; k < 50 && !cmd_ready; k++) tick();
    check("cmd_ready_before_cmd", ROW_W'(cmd_ready), ROW_W'(1));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  function automatic logic [ROW_W-1:0] row(input int i);
    logic [31:0] u;
    u = i;
    row = {32'hA500_0000 + u, ~u, u * 32'd3, u ^ 32'h5A5A_5A5A};
  endfunction

  initial begin
    int a0, b0, i0, d0, v0, beat, stall_exp;
    logic hs, prev_hold;
    logic [ROW_W-1:0] prev_data;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; pause_req = 1'b0; out_data_valid = 1'b0;
    for (int i = 0; i < 2048; i++) rmem[i] = row(i);
    repeat (3) tick();

    // Reset state
    check("rst_cmd_ready", ROW_W'(cmd_ready), '0);
    check("rst_busy", ROW_W'(busy), '0);
    check("rst_done_err", ROW_W'({done, err}), '0);
    check("rst_wr_ready_rd_valid", ROW_W'({wr_ready, rd_valid}), '0);
    check("rst_stall_idv", ROW_W'({stall, in_data_valid}), '0);
    check("rst_wr_ens", ROW_W'({bram_a_wr_en, bram_b_wr_en, bram_ins_wr_en}), '0);
    check("rst_rd_data", rd_data, '0);
    check("rst_r_addr", ROW_W'(bram_r_r_addr), '0);
    rst = 1'b0;
    tick();
    check("idle_cmd_ready", ROW_W'(cmd_ready), ROW_W'(1));

    // LOAD_A addr 5 len 3, wr_valid on every other cycle
    a0 = a_n; b0 = b_n; i0 = ins_n; d0 = done_n;
    send_cmd(3'd0, 11'd5, 11'd3);
    check("load_a_busy", ROW_W'(busy), ROW_W'(1));
    beat = 0;
    for (int c = 0; c < 40 && beat < 4; c++) begin
      wr_valid = (c % 2 == 0);
      wr_data  = ROW_W'(10 + beat);
      hs = wr_valid && wr_ready;
      tick();
      if (hs) begin
        beat++;
        if (beat == 4) begin
          check("load_a_last_wr_ready", ROW_W'(wr_ready), '0);
          check("load_a_last_en", ROW_W'(bram_a_wr_en), ROW_W'(1));
          check("load_a_last_addr", ROW_W'(bram_a_wr_addr), ROW_W'(8));
          check("load_a_last_done", ROW_W'(done), ROW_W'(1));
        end
      end
    end
    wr_valid = 1'b0;
    check("load_a_beats", ROW_W'(beat), ROW_W'(4));
    repeat (3) tick();
    check("load_a_count", ROW_W'(a_n - a0), ROW_W'(4));
    for (int k = 0; k < 4; k++) begin
      check("load_a_addr", ROW_W'(a_log_addr[a0 + k]), ROW_W'(5 + k));
      check("load_a_data", a_log_data[a0 + k], ROW_W'(10 + k));
    end
    check("load_a_b_en", ROW_W'(b_n - b0), '0);
    check("load_a_ins_en", ROW_W'(ins_n - i0), '0);
    check("load_a_done_count", ROW_W'(done_n - d0), ROW_W'(1));

    // LOAD_INS addr 2046 len 2, wraps to row 0
    i0 = ins_n; a0 = a_n; d0 = done_n;
    send_cmd(3'd2, 11'd2046, 11'd2);
    beat = 0;
    for (int c = 0; c < 20 && beat < 3; c++) begin
      wr_valid = 1'b1;
      wr_data  = {64'hFFFF_0000_1111_2222, 64'h0123_4567_89AB_0000 + 64'(beat)};
      hs = wr_valid && wr_ready;
      tick();
      if (hs) beat++;
    end
    wr_valid = 1'b0;
    repeat (3) tick();
    check("load_ins_count", ROW_W'(ins_n - i0), ROW_W'(3));
    check("load_ins_addr0", ROW_W'(ins_log_addr[i0]), ROW_W'(2046));
    check("load_ins_addr1", ROW_W'(ins_log_addr[i0 + 1]), ROW_W'(2047));
    check("load_ins_addr2", ROW_W'(ins_log_addr[i0 + 2]), ROW_W'(0));
    check("load_ins_data0", ROW_W'(ins_log_data[i0]), ROW_W'(64'h0123_4567_89AB_0000));
    check("load_ins_data2", ROW_W'(ins_log_data[i0 + 2]), ROW_W'(64'h0123_4567_89AB_0002));
    check("load_ins_a_en", ROW_W'(a_n - a0), '0);
    check("load_ins_done_count", ROW_W'(done_n - d0), ROW_W'(1));

    // RUN with out_data_valid already high, then dropped, then raised 40 cycles later
    out_data_valid = 1'b1;
    tick();
    d0 = done_n; v0 = idv_n;
    send_cmd(3'd3, 11'd0, 11'd0);
    check("run_idv_1", ROW_W'(in_data_valid), ROW_W'(1));
    tick();
    check("run_idv_2", ROW_W'(in_data_valid), ROW_W'(1));
    tick();
    check("run_idv_off", ROW_W'(in_data_valid), '0);
    for (int k = 0; k < 5; k++) begin
      check("run_level_no_done", ROW_W'({done, busy}), ROW_W'(2'b01));
      tick();
    end
    out_data_valid = 1'b0;
    repeat (40) tick();
    check("run_still_busy", ROW_W'({done, busy}), ROW_W'(2'b01));
    out_data_valid = 1'b1;
    tick();
    check("run_done_after_rise", ROW_W'(done), ROW_W'(1));
    tick();
    check("run_done_pulse_end", ROW_W'({done, busy, err}), '0);
    check("run_idv_count", ROW_W'(idv_n - v0), ROW_W'(2));
    check("run_done_count", ROW_W'(done_n - d0), ROW_W'(1));
    out_data_valid = 1'b0;
    tick();

    // RUN timeout with a 10-cycle pause in WAIT
    send_cmd(3'd3, 11'd0, 11'd0);
    tick();
    tick();
    for (int w = 0; w < 110; w++) begin
      stall_exp = (w >= 21 && w <= 30) ? 1 : 0;
      check("tmo_stall", ROW_W'(stall), ROW_W'(stall_exp));
      if (w == 0 || w == 109) check("tmo_waiting", ROW_W'({busy, done, err}), ROW_W'(3'b100));
      pause_req = (w >= 20 && w <= 29);
      tick();
    end
    pause_req = 1'b0;
    check("tmo_err_done", ROW_W'({err, done}), ROW_W'(2'b11));
    tick();
    check("tmo_after", ROW_W'({err, done, busy}), ROW_W'(3'b100));

    // READ_R addr 0 len 49 with random rd_ready; err cleared by the accept
    send_cmd(3'd4, 11'd0, 11'd49);
    check("read_err_cleared", ROW_W'(err), '0);
    beat = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 2000 && beat < 50; c++) begin
      if (prev_hold) begin
        check("read_hold_valid", ROW_W'(rd_valid), ROW_W'(1));
        check("read_hold_data", rd_data, prev_data);
      end
      rd_ready = 1'($urandom_range(0, 1));
      if (rd_valid && rd_ready) begin
        check("read_beat_data", rd_data, row(beat));
        beat++;
      end
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
      tick();
    end
    rd_ready = 1'b0;
    check("read_beats", ROW_W'(beat), ROW_W'(50));
    check("read_done", ROW_W'({done, busy}), ROW_W'(2'b10));

    // Illegal opcode
    tick();
    send_cmd(3'd6, 11'd0, 11'd0);
    check("illegal_err_done", ROW_W'({err, done}), ROW_W'(2'b11));
    tick();
    check("illegal_after", ROW_W'({err, done, busy, cmd_ready}), ROW_W'(4'b1001));

    // Reset in the middle of LOAD_B
    b0 = b_n; d0 = done_n;
    send_cmd(3'd1, 11'd100, 11'd7);
    wr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_data = ROW_W'(32'h77 + k);
      tick();
    end
    check("midload_b_en", ROW_W'(bram_b_wr_en), ROW_W'(1));
    rst = 1'b1;
    tick();
    check("midload_rst_en", ROW_W'({bram_a_wr_en, bram_b_wr_en, bram_ins_wr_en}), '0);
    check("midload_rst_ctrl", ROW_W'({cmd_ready, wr_ready, busy, done, err}), '0);
    check("midload_rst_b_addr", ROW_W'(bram_b_wr_addr), '0);
    check("midload_rst_b_data", bram_b_wr_data, '0);
    rst = 1'b0;
    wr_valid = 1'b0;
    repeat (3) tick();
    check("midload_b_count", ROW_W'(b_n - b0), ROW_W'(3));
    check("midload_no_done", ROW_W'(done_n - d0), '0);
    check("midload_idle", ROW_W'({busy, cmd_ready}), ROW_W'(2'b01));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
